// File: rtl/bnn_frame_controller.sv
// SPI image receiver and BNN handshake controller: one chip-select frame fills img_data,
// which is offered to the BNN core; the class result is then held until the host acks it.
// Optional replay of the current image on debug_trigger: define BNN_FRAME_CTRL_DEBUG_EN.
module bnn_frame_controller #(
  parameter int IMG_BITS    = 900,
  parameter int RESULT_W    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SCLK,
  input  logic                COPI,
  input  logic                spi_cs_n,
  output logic [IMG_BITS-1:0] img_data,
  output logic                img_valid,
  input  logic                img_ready,
  input  logic                bnn_valid,
  input  logic [RESULT_W-1:0] bnn_result,
  output logic [RESULT_W-1:0] result_out,
  output logic                result_ready,
  input  logic                result_ack,
  output logic                send_image,
  output logic                status_ready,
  output logic                frame_error,
  input  logic                debug_trigger
);

  localparam int CNT_W = $clog2(IMG_BITS + 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IMG_BITS);
  localparam logic [CNT_W-1:0] OVF_CNT  = CNT_W'(IMG_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    ISSUE,
    WAIT_RESULT,
    RESULT
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, cs_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_rise, cs_fall, cs_rise, cs_level, copi_bit;
  logic [CNT_W-1:0]       count, count_next;
  logic                   bit_write, frame_bad, dbg_rise;

  // cs synchroniser resets high so that a released bus never looks like a frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign cs_level  = cs_sync[SYNC_STAGES-1];
  assign copi_bit  = copi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign cs_fall   = ~cs_level & cs_prev;
  assign cs_rise   = cs_level & ~cs_prev;

`ifdef BNN_FRAME_CTRL_DEBUG_EN
  logic dbg_r, dbg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_r <= 1'b0;
      dbg_q <= 1'b0;
    end else begin
      dbg_r <= debug_trigger;
      dbg_q <= dbg_r;
    end
  end

  assign dbg_rise = dbg_r & ~dbg_q;
`else
  logic unused_debug;

  assign unused_debug = debug_trigger;
  assign dbg_rise     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A bit arriving together with cs rise is counted before the frame length is judged
  always_comb begin
    state_next = state;
    count_next = count;
    bit_write  = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          count_next = '0;
          state_next = RECEIVE;
        end else if (dbg_rise) begin
          state_next = ISSUE;
        end
      end
      RECEIVE: begin
        if (sclk_rise && (!cs_level || cs_rise)) begin
          if (count < FULL_CNT) begin
            bit_write  = 1'b1;
            count_next = count + 1'b1;
          end else begin
            count_next = OVF_CNT;
          end
        end
        if (cs_rise) begin
          if (count_next == FULL_CNT) begin
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
            frame_bad  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (img_ready) state_next = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (bnn_valid) state_next = RESULT;
      end
      RESULT: begin
        if (result_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      img_data    <= '0;
      result_out  <= '0;
      frame_error <= 1'b0;
    end else begin
      count       <= count_next;
      frame_error <= frame_bad;
      if (state == WAIT_RESULT && bnn_valid) result_out <= bnn_result;
      for (int i = 0; i < IMG_BITS; i++) begin
        if (bit_write && count == CNT_W'(i)) img_data[i] <= copi_bit;
      end
    end
  end

  assign img_valid    = (state == ISSUE);
  assign result_ready = (state == RESULT);
  assign send_image   = (state == IDLE);
  assign status_ready = (state == IDLE) || (state == RECEIVE);

endmodule

// File: tb/tb_bnn_frame_controller.sv
// Directed bench for bnn_frame_controller with a 16-pixel image and hand-computed
// expected buffers (a frame sent MSB-first lands bit-reversed in img_data).
`timescale 1ns/1ps
module tb_bnn_frame_controller;

  localparam int IMG_BITS    = 16;
  localparam int RESULT_W    = 4;
  localparam int SYNC_STAGES = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                SCLK, COPI, spi_cs_n;
  logic [IMG_BITS-1:0] img_data;
  logic                img_valid, img_ready, bnn_valid;
  logic [RESULT_W-1:0] bnn_result, result_out;
  logic                result_ready, result_ack;
  logic                send_image, status_ready, frame_error, debug_trigger;

  int total      = 0;
  int bad        = 0;
  int err_pulses = 0;
  int err_base   = 0;
  int seen       = 0;

  bnn_frame_controller #(
    .IMG_BITS    (IMG_BITS),
    .RESULT_W    (RESULT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .SCLK          (SCLK),
    .COPI          (COPI),
    .spi_cs_n      (spi_cs_n),
    .img_data      (img_data),
    .img_valid     (img_valid),
    .img_ready     (img_ready),
    .bnn_valid     (bnn_valid),
    .bnn_result    (bnn_result),
    .result_out    (result_out),
    .result_ready  (result_ready),
    .result_ack    (result_ack),
    .send_image    (send_image),
    .status_ready  (status_ready),
    .frame_error   (frame_error),
    .debug_trigger (debug_trigger)
  );

  always #5 clk = ~clk;

  // Each cycle frame_error is high adds one, so a clean pulse adds exactly one
  always @(negedge clk) if (frame_error) err_pulses++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spiBit(input logic b);
    COPI = b;
    tick(4);
    SCLK = 1'b1;
    tick(4);
    SCLK = 1'b0;
  endtask

  task automatic csLow();
    spi_cs_n = 1'b0;
    tick(6);
  endtask

  task automatic csHigh();
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic applyStimulus(input logic [31:0] data, input int nbits);
    csLow();
    for (int i = nbits - 1; i >= 0; i--) spiBit(data[i]);
    csHigh();
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (img_valid !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    checkOutput(tag, {31'd0, img_valid}, 32'd1);
  endtask

  task automatic pulseResult(input logic [RESULT_W-1:0] r);
    bnn_result = r;
    bnn_valid  = 1'b1;
    tick(1);
    bnn_valid  = 1'b0;
  endtask

  task automatic pulseAck();
    result_ack = 1'b1;
    tick(1);
    result_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; SCLK = 1'b0; COPI = 1'b0; spi_cs_n = 1'b1;
    img_ready = 1'b0; bnn_valid = 1'b0; bnn_result = '0; result_ack = 1'b0; debug_trigger = 1'b0;
    tick(3);
    checkOutput("rst_send_image", {31'd0, send_image}, 32'd1);
    checkOutput("rst_status_ready", {31'd0, status_ready}, 32'd1);
    checkOutput("rst_img_valid", {31'd0, img_valid}, 32'd0);
    checkOutput("rst_result_ready", {31'd0, result_ready}, 32'd0);
    checkOutput("rst_frame_error", {31'd0, frame_error}, 32'd0);
    checkOutput("rst_result_out", {28'd0, result_out}, 32'd0);
    checkOutput("rst_img_data", {16'd0, img_data}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Good frame, then 10 cycles of backpressure
    applyStimulus(32'hA5C3, 16);
    waitValid("good_valid");
    checkOutput("good_img_data", {16'd0, img_data}, 32'hC3A5);
    checkOutput("good_status_ready", {31'd0, status_ready}, 32'd0);
    checkOutput("good_send_image", {31'd0, send_image}, 32'd0);
    checkOutput("good_no_error", err_pulses, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("bp_valid", {31'd0, img_valid}, 32'd1);
      checkOutput("bp_data", {16'd0, img_data}, 32'hC3A5);
    end
    img_ready = 1'b1;
    tick(1);
    img_ready = 1'b0;
    checkOutput("hs_valid_drop", {31'd0, img_valid}, 32'd0);
    checkOutput("hs_status_busy", {31'd0, status_ready}, 32'd0);
    pulseResult(4'd7);
    checkOutput("res_ready", {31'd0, result_ready}, 32'd1);
    checkOutput("res_value", {28'd0, result_out}, 32'd7);
    pulseResult(4'd2);
    checkOutput("res_ignore_late_valid", {28'd0, result_out}, 32'd7);
    pulseAck();
    checkOutput("ack_result_ready", {31'd0, result_ready}, 32'd0);
    checkOutput("ack_send_image", {31'd0, send_image}, 32'd1);
    checkOutput("ack_result_hold", {28'd0, result_out}, 32'd7);
    pulseResult(4'd5);
    checkOutput("idle_ignore_valid", {28'd0, result_out}, 32'd7);
    checkOutput("idle_no_result_ready", {31'd0, result_ready}, 32'd0);

    // Handshake in the first ISSUE cycle, then a full frame while busy
    img_ready = 1'b1;
    applyStimulus(32'h00FF, 16);
    img_ready = 1'b0;
    checkOutput("fast_hs_valid", {31'd0, img_valid}, 32'd0);
    checkOutput("fast_hs_busy", {31'd0, status_ready}, 32'd0);
    checkOutput("fast_hs_data", {16'd0, img_data}, 32'hFF00);
    err_base = err_pulses;
    applyStimulus(32'hA5C3, 16);
    checkOutput("busy_data_kept", {16'd0, img_data}, 32'hFF00);
    checkOutput("busy_no_error", err_pulses - err_base, 32'd0);
    checkOutput("busy_no_valid", {31'd0, img_valid}, 32'd0);
    pulseResult(4'd9);
    checkOutput("busy_res_value", {28'd0, result_out}, 32'd9);
    pulseAck();

    // Short and long frames
    err_base = err_pulses;
    applyStimulus(32'h7FFF, 15);
    tick(4);
    checkOutput("short_error", err_pulses - err_base, 32'd1);
    checkOutput("short_no_valid", {31'd0, img_valid}, 32'd0);
    checkOutput("short_idle", {31'd0, send_image}, 32'd1);
    err_base = err_pulses;
    applyStimulus(32'h1FFFF, 17);
    tick(4);
    checkOutput("long_error", err_pulses - err_base, 32'd1);
    checkOutput("long_no_valid", {31'd0, img_valid}, 32'd0);
    checkOutput("long_idle", {31'd0, send_image}, 32'd1);

    // cs already low on entry to IDLE must not start a frame
    img_ready = 1'b1;
    applyStimulus(32'hA5C3, 16);
    img_ready = 1'b0;
    pulseResult(4'd3);
    spi_cs_n = 1'b0;
    tick(6);
    pulseAck();
    err_base = err_pulses;
    for (int i = 0; i < 16; i++) spiBit(1'b0);
    csHigh();
    checkOutput("stale_cs_no_valid", {31'd0, img_valid}, 32'd0);
    checkOutput("stale_cs_idle", {31'd0, send_image}, 32'd1);
    checkOutput("stale_cs_data", {16'd0, img_data}, 32'hC3A5);
    checkOutput("stale_cs_no_error", err_pulses - err_base, 32'd0);

    // Reset in the middle of a frame
    csLow();
    for (int i = 0; i < 8; i++) spiBit(1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rst_rx_status", {31'd0, status_ready}, 32'd1);
    checkOutput("rst_rx_send", {31'd0, send_image}, 32'd1);
    checkOutput("rst_rx_valid", {31'd0, img_valid}, 32'd0);
    checkOutput("rst_rx_result_out", {28'd0, result_out}, 32'd0);
    checkOutput("rst_rx_img_data", {16'd0, img_data}, 32'd0);
    spi_cs_n = 1'b1;
    err_base = err_pulses;
    tick(4);
    rst = 1'b0;
    tick(4);
    checkOutput("rst_rx_no_error", err_pulses - err_base, 32'd0);
    applyStimulus(32'h5A3C, 16);
    waitValid("after_rst_valid");
    checkOutput("after_rst_data", {16'd0, img_data}, 32'h3C5A);
    img_ready = 1'b1;
    tick(1);
    img_ready = 1'b0;
    pulseResult(4'hB);
    checkOutput("after_rst_result", {28'd0, result_out}, 32'hB);

    // Reset while a result is held
    rst = 1'b1;
    #1;
    checkOutput("rst_res_ready", {31'd0, result_ready}, 32'd0);
    checkOutput("rst_res_out", {28'd0, result_out}, 32'd0);
    checkOutput("rst_res_img_data", {16'd0, img_data}, 32'd0);
    checkOutput("rst_res_send", {31'd0, send_image}, 32'd1);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Replay request after a completed frame
    img_ready = 1'b1;
    applyStimulus(32'hA5C3, 16);
    img_ready = 1'b0;
    pulseResult(4'd4);
    pulseAck();
    debug_trigger = 1'b1;
    tick(2);
    debug_trigger = 1'b0;
`ifdef BNN_FRAME_CTRL_DEBUG_EN
    waitValid("dbg_replay_valid");
    checkOutput("dbg_replay_data", {16'd0, img_data}, 32'hC3A5);
    img_ready = 1'b1;
    tick(1);
    img_ready = 1'b0;
    pulseResult(4'd1);
    pulseAck();
`else
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (img_valid === 1'b1) seen++;
      tick(1);
    end
    checkOutput("dbg_ignored", seen, 32'd0);
    checkOutput("dbg_ignored_idle", {31'd0, send_image}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
